// File: rtl/gpio_periph.sv
// Memory-mapped switch/LED peripheral: 2-flop input sync, per-bit debounce, rising-edge
// capture (W1C) and atomic OUT set/clear/toggle. Define GPIO_IRQ_EN for IRQ_MASK and irq.
module gpio_periph #(
   parameter int unsigned IN_W       = 10,
   parameter int unsigned OUT_W      = 10,
   parameter int unsigned DEB_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cs,
   input  logic             we,
   input  logic [4:0]       addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   input  logic [IN_W-1:0]  switches,
`ifdef GPIO_IRQ_EN
   output logic             irq,
`endif
   output logic [OUT_W-1:0] leds
);

   localparam int unsigned CNT_W = (DEB_CYCLES > 0) ? $clog2(DEB_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((DEB_CYCLES > 0) ? DEB_CYCLES - 1 : 0);

   typedef enum logic [2:0] {
      REG_IN    = 3'd0,
      REG_OUT   = 3'd1,
      REG_SET   = 3'd2,
      REG_CLR   = 3'd3,
      REG_TGL   = 3'd4,
      REG_EDGE  = 3'd5,
      REG_MASK  = 3'd6,
      REG_RSVD  = 3'd7
   } reg_idx_e;

   reg_idx_e idx;
   logic     wr_en;

   logic [IN_W-1:0]  sync1_q, sync2_q;
   logic [IN_W-1:0]  deb_q, deb_d;
   logic [CNT_W-1:0] cnt_q [IN_W];
   logic [CNT_W-1:0] cnt_d [IN_W];
   logic [OUT_W-1:0] out_q, out_d;
   logic [IN_W-1:0]  edge_q, edge_d;
   logic [IN_W-1:0]  w1c;
   logic [31:0]      in_ext, out_ext, edge_ext;
`ifdef GPIO_IRQ_EN
   logic [IN_W-1:0]  mask_q, mask_d;
   logic [31:0]      mask_ext;
   logic             irq_q, irq_d;
`endif

   logic unused_bits;
   assign unused_bits = ^{addr[1:0], wdata};

   assign idx   = reg_idx_e'(addr[4:2]);
   assign wr_en = cs && we;
   assign leds  = out_q;

   always_comb begin
      for (int unsigned i = 0; i < IN_W; i++) begin
         deb_d[i] = deb_q[i];
         cnt_d[i] = '0;
         if (DEB_CYCLES == 0) begin
            deb_d[i] = sync2_q[i];
         end else if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               deb_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      out_d = out_q;
      w1c   = '0;
`ifdef GPIO_IRQ_EN
      mask_d = mask_q;
`endif
      if (wr_en) begin
         case (idx)
            REG_OUT:  out_d = wdata[OUT_W-1:0];
            REG_SET:  out_d = out_q | wdata[OUT_W-1:0];
            REG_CLR:  out_d = out_q & ~wdata[OUT_W-1:0];
            REG_TGL:  out_d = out_q ^ wdata[OUT_W-1:0];
            REG_EDGE: w1c   = wdata[IN_W-1:0];
`ifdef GPIO_IRQ_EN
            REG_MASK: mask_d = wdata[IN_W-1:0];
`endif
            default:  ;
         endcase
      end
      // Hardware set applied after the clear so a coincident rising edge wins.
      edge_d = (edge_q & ~w1c) | (deb_d & ~deb_q);
`ifdef GPIO_IRQ_EN
      irq_d = |(edge_q & mask_q);
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         deb_q   <= '0;
         out_q   <= '0;
         edge_q  <= '0;
         for (int unsigned i = 0; i < IN_W; i++) cnt_q[i] <= '0;
`ifdef GPIO_IRQ_EN
         mask_q  <= '0;
         irq_q   <= 1'b0;
`endif
      end else begin
         sync1_q <= switches;
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         out_q   <= out_d;
         edge_q  <= edge_d;
         for (int unsigned i = 0; i < IN_W; i++) cnt_q[i] <= cnt_d[i];
`ifdef GPIO_IRQ_EN
         mask_q  <= mask_d;
         irq_q   <= irq_d;
`endif
      end
   end

`ifdef GPIO_IRQ_EN
   assign irq = irq_q;
`endif

   always_comb begin
      in_ext   = '0;
      out_ext  = '0;
      edge_ext = '0;
      in_ext[IN_W-1:0]    = deb_q;
      out_ext[OUT_W-1:0]  = out_q;
      edge_ext[IN_W-1:0]  = edge_q;
`ifdef GPIO_IRQ_EN
      mask_ext = '0;
      mask_ext[IN_W-1:0]  = mask_q;
`endif
      rdata = '0;
      if (cs) begin
         case (idx)
            REG_IN:   rdata = in_ext;
            REG_OUT:  rdata = out_ext;
            REG_EDGE: rdata = edge_ext;
`ifdef GPIO_IRQ_EN
            REG_MASK: rdata = mask_ext;
`endif
            default:  rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_gpio_periph.sv
// Self-checking bench for gpio_periph (default parameters); irq checks when GPIO_IRQ_EN is defined.
module tb_gpio_periph;

   logic        clk = 1'b0;
   logic        reset;
   logic        cs, we;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [9:0]  switches;
   logic [9:0]  leds;
`ifdef GPIO_IRQ_EN
   logic        irq;
`endif

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sb_entry_t;
   sb_entry_t sb_q[$];

   gpio_periph #(.IN_W(10), .OUT_W(10), .DEB_CYCLES(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .cs       (cs),
      .we       (we),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .switches (switches),
`ifdef GPIO_IRQ_EN
      .irq      (irq),
`endif
      .leds     (leds)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [31:0] exp);
      sb_entry_t e;
      e.tag = tag;
      e.exp = exp;
      sb_q.push_back(e);
   endtask

   task automatic sb_pop_check(input logic [31:0] obs);
      sb_entry_t e;
      if (sb_q.size() == 0) begin
         check_eq("sb_underflow", 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         check_eq(e.tag, obs, e.exp);
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input int idx, input logic [31:0] data);
      cs = 1'b1; we = 1'b1; addr = 5'(idx << 2); wdata = data;
      @(negedge clk);
      cs = 1'b0; we = 1'b0; wdata = '0;
   endtask

   task automatic chk_reg(input int idx, input logic [31:0] exp, input string tag);
      cs = 1'b1; we = 1'b0; addr = 5'(idx << 2);
      sb_push(tag, exp);
      #1;
      sb_pop_check(rdata);
      cs = 1'b0;
   endtask

   task automatic chk_leds(input logic [31:0] exp, input string tag);
      sb_push(tag, exp);
      #1;
      sb_pop_check({22'b0, leds});
   endtask

`ifdef GPIO_IRQ_EN
   task automatic chk_irq(input logic exp, input string tag);
      sb_push(tag, {31'b0, exp});
      #1;
      sb_pop_check({31'b0, irq});
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; cs = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      switches = 10'h3FF;
      ticks(2);
      chk_leds(32'h0, "rst_leds");
      chk_reg(0, 32'h0, "rst_in");
      chk_reg(5, 32'h0, "rst_edge");
      reset = 1'b0;

      ticks(5);
      chk_reg(0, 32'h0, "in_edge5");
      ticks(1);
      chk_reg(0, 32'h3FF, "in_edge6");
      chk_reg(5, 32'h3FF, "edge_all");

      wr(5, 32'h3FF);
      chk_reg(5, 32'h0, "edge_w1c_all");
      switches = 10'h000;
      ticks(8);
      chk_reg(0, 32'h0, "in_fall");
      chk_reg(5, 32'h0, "edge_no_fall");

      switches = 10'd4;
      ticks(5);
      chk_reg(0, 32'h0, "deb_edge5");
      ticks(1);
      chk_reg(0, 32'h004, "deb_edge6");
      chk_reg(5, 32'h004, "deb_edge_bit2");

      switches[5] = 1'b1;
      ticks(3);
      switches[5] = 1'b0;
      ticks(8);
      chk_reg(0, 32'h004, "glitch_in");
      chk_reg(5, 32'h004, "glitch_edge");

      switches = 10'h00C;
      ticks(5);
      wr(5, 32'h004);
      chk_reg(0, 32'h00C, "race_in");
      chk_reg(5, 32'h008, "race_edge");
      wr(5, 32'h008);
      chk_reg(5, 32'h0, "race_clear");

      wr(1, 32'h0F0);
      chk_leds(32'h0F0, "led_wr");
      wr(2, 32'h00F);
      chk_leds(32'h0FF, "led_set");
      wr(3, 32'h030);
      chk_leds(32'h0CF, "led_clr");
      wr(4, 32'h300);
      chk_leds(32'h3CF, "led_tgl");
      chk_reg(2, 32'h0, "rd_set_wo");
      chk_reg(1, 32'h3CF, "rd_out");

      wr(1, 32'hFFFF_FFFF);
      chk_reg(1, 32'h3FF, "out_width");
      wr(7, 32'h0);
      chk_reg(1, 32'h3FF, "rsvd_wr");
      chk_reg(7, 32'h0, "rsvd_rd");
      cs = 1'b0; we = 1'b1; addr = 5'(1 << 2); wdata = 32'h0;
      #1;
      sb_push("cs0_rdata", 32'h0);
      sb_pop_check(rdata);
      ticks(1);
      we = 1'b0;
      chk_reg(1, 32'h3FF, "cs0_nowrite");

`ifdef GPIO_IRQ_EN
      switches = 10'h008;
      ticks(8);
      chk_reg(5, 32'h0, "irq_pre_edge");
      wr(6, 32'hFFFF_F004);
      chk_reg(6, 32'h004, "mask_rd");
      switches = 10'h00C;
      ticks(6);
      chk_reg(5, 32'h004, "irq_edge_set");
      chk_irq(1'b0, "irq_not_yet");
      ticks(1);
      chk_irq(1'b1, "irq_assert");
      wr(5, 32'h004);
      chk_irq(1'b1, "irq_hold");
      ticks(1);
      chk_irq(1'b0, "irq_deassert");
      switches = 10'h00D;
      ticks(8);
      chk_reg(5, 32'h001, "unmasked_edge");
      chk_irq(1'b0, "irq_unmasked");
`else
      wr(6, 32'h004);
      chk_reg(6, 32'h0, "mask_absent");
`endif

      reset = 1'b1;
      cs = 1'b1; we = 1'b1; addr = 5'(1 << 2); wdata = 32'h155;
      ticks(1);
      cs = 1'b0; we = 1'b0;
      reset = 1'b0;
      chk_leds(32'h0, "rst_over_wr");

      if (sb_q.size() != 0) check_eq("sb_leftover", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
